fault_pattern_checker: RTL and testbench
========================================

# fault_pattern_checker

Exhaustive stimulus generator and response checker for the small combinational fault-test circuits in this codebase. It drives every 4-bit input pattern onto {a,b,c,e} of a device-under-test and a golden copy at the same time, waits a fixed settle time, then compares their y/z outputs. It accumulates a mismatch count, the first failing pattern, and a per-output failure mask. It sits directly upstream of the circuit under test, which is the block it feeds, and also consumes that circuit's outputs.

## Interface
- SETTLE_CYCLES, 2, cycles each pattern is held before sampling; legal range 1..15
- PAT_W, 4, pattern width; fixed at 4 (a,b,c,e)

- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; accepted only in IDLE
- pat_out  output  PAT_W  applied pattern: [3]=a, [2]=b, [1]=c, [0]=e
- dut_y, dut_z  input  1 each  outputs of the circuit under test
- ref_y, ref_z  input  1 each  outputs of the golden circuit
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  high when fail_cnt==0; valid from done onward
- fail_cnt  output  PAT_W+1  number of mismatching patterns (0..16)
- first_fail_pat  output  PAT_W  first mismatching pattern
- first_fail_vld  output  1  high when first_fail_pat holds a valid value
- fail_mask  output  2  sticky per-output mismatch flags: [1]=y, [0]=z
- signature  output  8  MISR of DUT responses (see Configuration)

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE to SETTLE on start. On the same edge:
  - pat_out <= 0; counters, mask and first_fail are cleared
  - pass <= 0; signature <= 8'hFF
- SETTLE: held for SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE: one cycle. At the closing edge the checker compares {dut_y,dut_z} against {ref_y,ref_z}. On a mismatch:
  - fail_cnt increments
  - fail_mask |= {y_mis, z_mis}
  - if first_fail_vld==0: first_fail_pat <= pat_out and first_fail_vld <= 1
- At that same edge: if pat_out==4'hF, go to DONE; otherwise pat_out increments and the FSM returns to SETTLE.
- DONE: one cycle; done=1, pass registered as (fail_cnt==0). Then returns to IDLE.
- Result outputs hold until the next accepted start or rst.
- start in any state other than IDLE is ignored. This includes the DONE cycle.
- pat_out never wraps within a run. The run ends after pattern 4'hF.
- Inputs are sampled only in the SAMPLE cycle. dut/ref values at other times have no effect.
- Reset values: pat_out=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_pat=0, first_fail_vld=0, fail_mask=0, signature=0, state=IDLE.
- rst mid-run aborts immediately to reset values. No partial result is kept.

## Timing
- Call the start-accept edge cycle 0 and let S=SETTLE_CYCLES.
- Pattern k appears on pat_out in cycles 1+k(S+1) through (k+1)(S+1). It is sampled at the end of the last of those cycles.
- busy is high in cycles 1..16(S+1).
- done is high in cycle 16(S+1)+1. With S=2, that is cycle 49.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro SIG_MISR_EN:
  - Defined: signature is an 8-bit MISR updated at each SAMPLE edge with sig <= {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {6'b0,dut_y,dut_z}. The seed is 8'hFF at start.
  - Undefined: the MISR logic is absent and signature is tied to 8'h00. The port remains.

## Test plan
- Baseline: dut tied to ref, S=2, start at cycle 0 -> done in cycle 49, fail_cnt=0, pass=1, first_fail_vld=0, fail_mask=2'b00.
- Selective z fault: ref_z=1 only for patterns 5 and 9, dut_z=0 always, y outputs equal -> fail_cnt=2, first_fail_pat=4'd5, first_fail_vld=1, fail_mask=2'b01, pass=0.
- Full y fault: dut_y=~ref_y for all patterns -> fail_cnt=16, first_fail_pat=0, fail_mask=2'b10, pass=0.
- Start rejection: start pulsed again at cycle 10 -> ignored, done still in cycle 49. A start one cycle after done begins a new run with cleared results.
- Reset mid-run: rst high in cycle 20 -> cycle 21 shows busy=0, pat_out=0, fail_cnt=0, no done pulse. A subsequent start completes a normal run.
- MISR (SIG_MISR_EN defined): dut_y=dut_z=0 for all 16 patterns -> signature=8'h41 at done. Without the macro, signature=8'h00.

Source files
------------

// File: rtl/fault_pattern_checker.sv
// Exhaustive 4-bit pattern generator and DUT/golden response checker.
// Optional MISR over DUT responses is enabled by defining SIG_MISR_EN.
module fault_pattern_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PAT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PAT_W-1:0] pat_out,
    input  logic             dut_y,
    input  logic             dut_z,
    input  logic             ref_y,
    input  logic             ref_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [PAT_W:0]   fail_cnt,
    output logic [PAT_W-1:0] first_fail_pat,
    output logic             first_fail_vld,
    output logic [1:0]       fail_mask,
    output logic [7:0]       signature
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0]       SET_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [PAT_W-1:0] PAT_ONE  = 1;
    localparam logic [PAT_W-1:0] PAT_LAST = '1;
    localparam logic [PAT_W:0]   CNT_ONE  = 1;

    state_t         state;
    state_t         state_n;
    logic [3:0]     cnt;
    logic [1:0]     mis;
    logic           hit;
    logic [PAT_W:0] fail_nxt;

    assign mis      = {dut_y ^ ref_y, dut_z ^ ref_z};
    assign hit      = |mis;
    assign fail_nxt = hit ? fail_cnt + CNT_ONE : fail_cnt;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SETTLE;
            SETTLE:  if (cnt == SET_LAST) state_n = SAMPLE;
            SAMPLE:  state_n = (pat_out == PAT_LAST) ? DONE : SETTLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            pat_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_pat <= '0;
            first_fail_vld <= 1'b0;
            fail_mask      <= '0;
`ifdef SIG_MISR_EN
            signature      <= '0;
`endif
        end else begin
            state <= state_n;
            busy  <= (state_n == SETTLE) || (state_n == SAMPLE);
            done  <= (state_n == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt            <= '0;
                        pat_out        <= '0;
                        pass           <= 1'b0;
                        fail_cnt       <= '0;
                        first_fail_pat <= '0;
                        first_fail_vld <= 1'b0;
                        fail_mask      <= '0;
`ifdef SIG_MISR_EN
                        signature      <= 8'hFF;
`endif
                    end
                end
                SETTLE: cnt <= cnt + 4'd1;
                SAMPLE: begin
                    cnt       <= '0;
                    fail_cnt  <= fail_nxt;
                    fail_mask <= fail_mask | mis;
                    if (hit && !first_fail_vld) begin
                        first_fail_pat <= pat_out;
                        first_fail_vld <= 1'b1;
                    end
`ifdef SIG_MISR_EN
                    signature <= {signature[6:0], 1'b0}
                               ^ (signature[7] ? 8'h1D : 8'h00)
                               ^ {6'b0, dut_y, dut_z};
`endif
                    // Final pattern: latch the verdict so it is valid with done.
                    if (pat_out == PAT_LAST) pass <= (fail_nxt == '0);
                    else pat_out <= pat_out + PAT_ONE;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

`ifndef SIG_MISR_EN
    assign signature = 8'h00;
`endif

endmodule

// File: tb/tb_fault_pattern_checker.sv
// Randomized self-checking bench for fault_pattern_checker against a
// table-driven reference model of a full 16-pattern run.
module tb_fault_pattern_checker;

    localparam int S     = 2;
    localparam int DONEC = 16 * (S + 1) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pat_out;
    logic       dut_y, dut_z, ref_y, ref_z;
    logic       busy, done, pass;
    logic [4:0] fail_cnt;
    logic [3:0] first_fail_pat;
    logic       first_fail_vld;
    logic [1:0] fail_mask;
    logic [7:0] signature;

    logic [15:0] dy, dz, ry, rz;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Responses of both circuits are pure functions of the applied pattern.
    assign dut_y = dy[pat_out];
    assign dut_z = dz[pat_out];
    assign ref_y = ry[pat_out];
    assign ref_z = rz[pat_out];

    fault_pattern_checker #(.SETTLE_CYCLES(S), .PAT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_out(pat_out),
        .dut_y(dut_y), .dut_z(dut_z), .ref_y(ref_y), .ref_z(ref_z),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail_pat(first_fail_pat), .first_fail_vld(first_fail_vld),
        .fail_mask(fail_mask), .signature(signature)
    );

    function automatic void model(output int cnt, output logic [3:0] ffp,
                                  output logic ffv, output logic [1:0] msk,
                                  output logic [7:0] sig);
        cnt = 0; ffp = 0; ffv = 0; msk = 0; sig = 8'hFF;
        for (int p = 0; p < 16; p++) begin
            logic ym, zm;
            ym = dy[p] != ry[p];
            zm = dz[p] != rz[p];
            if (ym || zm) begin
                cnt++;
                if (!ffv) begin ffp = 4'(p); ffv = 1; end
            end
            if (ym) msk[1] = 1;
            if (zm) msk[0] = 1;
            sig = ((sig * 2) % 256) ^ (sig >= 128 ? 8'h1D : 8'h00)
                ^ {6'b0, dy[p], dz[p]};
        end
`ifndef SIG_MISR_EN
        sig = 8'h00;
`endif
    endfunction

    // Starts a run and follows it to done; returns observations only.
    task automatic run(input int extra_at, output int done_cyc,
                       output int busy_bad, output int pat_bad);
        done_cyc = -1; busy_bad = 0; pat_bad = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int n = 1; n <= 200; n++) begin
            start = (n == extra_at);
            if (busy !== (n <= 16 * (S + 1))) busy_bad++;
            if (n <= 16 * (S + 1) && pat_out !== 4'((n - 1) / (S + 1)))
                pat_bad++;
            if (done === 1'b1) begin
                done_cyc = n;
                break;
            end
            @(negedge clk);
        end
        start = 0;
    endtask

    task automatic test_reset();
        dy = 16'hFFFF; dz = 16'h0; ry = 16'h0; rz = 16'hFFFF;
        rst = 1; start = 1;
        repeat (3) @(negedge clk);
        start = 0;
        n_cmp++;
        if ({pat_out, busy, done, pass, fail_cnt, first_fail_pat,
             first_fail_vld, fail_mask, signature} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got pat=%h busy=%b done=%b pass=%b cnt=%0d ffp=%h ffv=%b mask=%b sig=%h, want all zero",
                     pat_out, busy, done, pass, fail_cnt, first_fail_pat,
                     first_fail_vld, fail_mask, signature);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_run(input string nm);
        int dc, bb, pb, ecnt;
        logic [3:0] effp;
        logic effv;
        logic [1:0] emsk;
        logic [7:0] esig;
        model(ecnt, effp, effv, emsk, esig);
        run(-1, dc, bb, pb);
        n_cmp++;
        if (dc != DONEC) begin
            n_bad++; $display("FAIL %s done_cycle: got %0d want %0d", nm, dc, DONEC);
        end
        n_cmp++;
        if (bb != 0 || pb != 0) begin
            n_bad++; $display("FAIL %s busy_pat: got %0d busy / %0d pat errors want 0", nm, bb, pb);
        end
        n_cmp++;
        if (fail_cnt !== 5'(ecnt) || pass !== (ecnt == 0)) begin
            n_bad++; $display("FAIL %s count: got cnt=%0d pass=%b want cnt=%0d pass=%b", nm, fail_cnt, pass, ecnt, ecnt == 0);
        end
        n_cmp++;
        if (first_fail_pat !== effp || first_fail_vld !== effv) begin
            n_bad++; $display("FAIL %s first: got %h/%b want %h/%b", nm, first_fail_pat, first_fail_vld, effp, effv);
        end
        n_cmp++;
        if (fail_mask !== emsk || signature !== esig) begin
            n_bad++; $display("FAIL %s mask_sig: got %b/%h want %b/%h", nm, fail_mask, signature, emsk, esig);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || fail_cnt !== 5'(ecnt) || fail_mask !== emsk) begin
            n_bad++; $display("FAIL %s hold: got done=%b busy=%b cnt=%0d mask=%b want 0/0/%0d/%b", nm, done, busy, fail_cnt, fail_mask, ecnt, emsk);
        end
    endtask

    task automatic test_baseline();
        ry = 16'($urandom); rz = 16'($urandom);
        dy = ry; dz = rz;
        test_run("baseline");
    endtask

    task automatic test_z_fault();
        ry = 16'($urandom); dy = ry; dz = 16'h0;
        rz = 16'h0; rz[5] = 1; rz[9] = 1;
        test_run("z_fault");
    endtask

    task automatic test_y_fault();
        ry = 16'($urandom); rz = 16'($urandom);
        dy = ~ry; dz = rz;
        test_run("y_fault");
    endtask

    task automatic test_misr_zero();
        dy = 16'h0; dz = 16'h0; ry = 16'($urandom); rz = 16'($urandom);
        test_run("misr_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            ry = 16'($urandom); rz = 16'($urandom);
            dy = ry ^ 16'($urandom & $urandom & $urandom);
            dz = rz ^ 16'($urandom & $urandom);
            test_run("random");
        end
    endtask

    task automatic test_start_reject();
        int dc, bb, pb, ecnt, lim;
        logic [3:0] effp;
        logic effv;
        logic [1:0] emsk;
        logic [7:0] esig;
        ry = 16'($urandom); rz = 16'($urandom);
        dy = ry ^ 16'h0F0F; dz = rz ^ 16'h8001;
        model(ecnt, effp, effv, emsk, esig);
        run(10, dc, bb, pb);
        n_cmp++;
        if (dc != DONEC || bb != 0 || pb != 0) begin
            n_bad++; $display("FAIL restart_ignored: got done=%0d busy_err=%0d pat_err=%0d want %0d/0/0", dc, bb, pb, DONEC);
        end
        n_cmp++;
        if (fail_cnt !== 5'(ecnt) || first_fail_pat !== effp) begin
            n_bad++; $display("FAIL restart_result: got cnt=%0d ffp=%h want %0d/%h", fail_cnt, first_fail_pat, ecnt, effp);
        end
        start = 1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL start_in_done: got busy=%b done=%b want 0/0", busy, done);
        end
        @(negedge clk);
        start = 0;
        n_cmp++;
        if (busy !== 1'b1 || fail_cnt !== 5'd0 || first_fail_vld !== 1'b0 ||
            fail_mask !== 2'b00 || pass !== 1'b0 || pat_out !== 4'h0) begin
            n_bad++; $display("FAIL new_run_clear: got busy=%b cnt=%0d ffv=%b mask=%b pass=%b pat=%h want 1/0/0/00/0/0",
                              busy, fail_cnt, first_fail_vld, fail_mask, pass, pat_out);
        end
        lim = 0;
        while (done !== 1'b1 && lim < 200) begin
            @(negedge clk); lim++;
        end
        n_cmp++;
        if (lim != DONEC - 1 || fail_cnt !== 5'(ecnt) || fail_mask !== emsk) begin
            n_bad++; $display("FAIL new_run_done: got wait=%0d cnt=%0d mask=%b want %0d/%0d/%b", lim, fail_cnt, fail_mask, DONEC - 1, ecnt, emsk);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int dones;
        ry = 16'($urandom); rz = 16'($urandom);
        dy = ~ry; dz = rz;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (19) @(negedge clk);
        n_cmp++;
        if (fail_cnt === 5'd0) begin
            n_bad++; $display("FAIL pre_reset_count: got %0d want nonzero", fail_cnt);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_cmp++;
        if (busy !== 1'b0 || pat_out !== 4'h0 || fail_cnt !== 5'd0 ||
            done !== 1'b0 || first_fail_vld !== 1'b0 || fail_mask !== 2'b00) begin
            n_bad++; $display("FAIL mid_reset: got busy=%b pat=%h cnt=%0d done=%b ffv=%b mask=%b want all zero",
                              busy, pat_out, fail_cnt, done, first_fail_vld, fail_mask);
        end
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++; $display("FAIL after_reset_idle: got %0d active cycles want 0", dones);
        end
        dy = ry;
        test_run("after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_baseline();
        test_z_fault();
        test_y_fault();
        test_misr_zero();
        test_random();
        test_start_reject();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
